// File: rtl/palette_pkg.sv
// Shared types, constants and the brightness-scaling helper for the palette engine.
package palette_pkg;

  localparam int COLOR_W   = 24;
  localparam int LEVEL_MAX = 16;
  localparam int LEVEL_W   = $clog2(LEVEL_MAX + 1);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    IDLE   = 1'b0,
    FADING = 1'b1
  } fade_state_t;

  // One channel scaled by level/16; the 13-bit product keeps ch*16 exact.
  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [LEVEL_W-1:0] lvl);
    logic [12:0] prod;
    prod = 13'(ch) * 13'(lvl);
    return 8'(prod >> 4);
  endfunction

  // Whole RGB888 pixel scaled channel by channel.
  function automatic logic [COLOR_W-1:0] scale_rgb(input logic [COLOR_W-1:0] c,
                                                   input logic [LEVEL_W-1:0] lvl);
    rgb_t px;
    rgb_t o;
    px   = c;
    o.r  = scale_ch(px.r, lvl);
    o.g  = scale_ch(px.g, lvl);
    o.b  = scale_ch(px.b, lvl);
    return o;
  endfunction

endpackage

// File: rtl/palette_engine_if.sv
// Bus bundle for the palette engine: lookup stream, palette write port, fade control.
//
// Handshakes: a lookup is taken every cycle pixel_valid is high (no back-pressure);
// a palette write transfers on a cycle where wr_valid && wr_ready, and wr_ready is
// low whenever a lookup is presented, because lookups own the single RAM port.
// wr_* must stay stable while wr_valid is high and wr_ready is low.
interface palette_engine_if
  import palette_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int IDX_W     = 8
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic               pixel_valid;
  logic [BANK_W-1:0]  bank_sel;
  logic [IDX_W-1:0]   pixel_idx;
  logic [COLOR_W-1:0] color_out;
  logic               color_valid;

  logic               wr_valid;
  logic               wr_ready;
  logic [BANK_W-1:0]  wr_bank;
  logic [IDX_W-1:0]   wr_addr;
  logic [COLOR_W-1:0] wr_data;

  logic               frame_tick;
  logic               fade_start;
  logic               fade_dir;
  logic               fade_busy;

  fade_state_t        dbg_state;
  logic [LEVEL_W-1:0] dbg_level;

  modport master (
    output pixel_valid, bank_sel, pixel_idx, wr_valid, wr_bank, wr_addr, wr_data,
           frame_tick, fade_start, fade_dir,
    input  color_out, color_valid, wr_ready, fade_busy, dbg_state, dbg_level
  );

  modport slave (
    input  pixel_valid, bank_sel, pixel_idx, wr_valid, wr_bank, wr_addr, wr_data,
           frame_tick, fade_start, fade_dir,
    output color_out, color_valid, wr_ready, fade_busy, dbg_state, dbg_level
  );

endinterface

// File: rtl/palette_ram.sv
// Single-port palette bank, synchronous read. Contents are never reset.
module palette_ram #(
  parameter int IDX_W  = 8,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              re,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**IDX_W];

  // Write or registered read on the shared address; the caller keeps re/we exclusive.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/palette_engine.sv
// Banked palette lookup with a two-stage pipeline (RAM read, then brightness
// scaling) and a frame-paced fade FSM that drives the brightness level.
module palette_engine
  import palette_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int IDX_W     = 8,
  parameter int FADE_DIV  = 2
) (
  input logic              Clk,
  input logic              Reset_n,
  palette_engine_if.slave  bus
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int DIV_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  logic [BANK_W-1:0]  rd_bank;
  logic [BANK_W-1:0]  wr_bank_eff;
  logic [BANK_W-1:0]  bank_q;
  logic               valid_q;
  logic               wr_fire;
  logic [IDX_W-1:0]   ram_addr;
  logic [COLOR_W-1:0] ram_q [NUM_BANKS];

  fade_state_t        state;
  logic [LEVEL_W-1:0] level;
  logic               dir_q;
  logic [DIV_W-1:0]   div_cnt;
  logic [LEVEL_W-1:0] end_level;
  logic [LEVEL_W-1:0] next_level;

  // Banks beyond the configured count fold onto bank 0.
  assign rd_bank     = (int'(bus.bank_sel) < NUM_BANKS) ? bus.bank_sel : '0;
  assign wr_bank_eff = (int'(bus.wr_bank) < NUM_BANKS) ? bus.wr_bank : '0;

  assign bus.wr_ready = !bus.pixel_valid;
  assign wr_fire      = bus.wr_valid && !bus.pixel_valid;
  assign ram_addr     = bus.pixel_valid ? bus.pixel_idx : bus.wr_addr;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    palette_ram #(.IDX_W(IDX_W), .DATA_W(COLOR_W)) u_ram (
      .clk   (Clk),
      .re    (bus.pixel_valid && (rd_bank == BANK_W'(b))),
      .we    (wr_fire && (wr_bank_eff == BANK_W'(b))),
      .addr  (ram_addr),
      .wdata (bus.wr_data),
      .rdata (ram_q[b])
    );
  end

  // Stage 1: remember which bank was read so the mux lines up with RAM data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q <= 1'b0;
      bank_q  <= '0;
    end else begin
      valid_q <= bus.pixel_valid;
      if (bus.pixel_valid) bank_q <= rd_bank;
    end
  end

  // Stage 2: select the bank and scale by the level current in this cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.color_valid <= 1'b0;
      bus.color_out   <= '0;
    end else begin
      bus.color_valid <= valid_q;
      if (valid_q) bus.color_out <= scale_rgb(ram_q[bank_q], level);
    end
  end

  assign end_level  = dir_q ? LEVEL_W'(LEVEL_MAX) : '0;
  assign next_level = dir_q ? (level + LEVEL_W'(1)) : (level - LEVEL_W'(1));

  // Fade FSM: one level step every FADE_DIV frame ticks until the endpoint.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      level   <= LEVEL_W'(LEVEL_MAX);
      dir_q   <= 1'b0;
      div_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.fade_start) begin
            state   <= FADING;
            dir_q   <= bus.fade_dir;
            div_cnt <= '0;
          end
        end
        FADING: begin
          if (level == end_level) begin
            state <= IDLE;
          end else if (bus.frame_tick) begin
            if (div_cnt == DIV_W'(FADE_DIV - 1)) begin
              div_cnt <= '0;
              level   <= next_level;
              if (next_level == end_level) state <= IDLE;
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fade_busy = (state == FADING);
  assign bus.dbg_state = state;
  assign bus.dbg_level = level;

endmodule

// File: tb/tb_palette_engine.sv
// Directed bench for palette_engine. Three banks are configured so that bank
// index 3 exists on the 2-bit select and exercises the fold-to-bank-0 path.
module tb_palette_engine;
  import palette_pkg::*;

  localparam int NB = 3;
  localparam int IW = 8;
  localparam int FD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  // Clock / reset
  always #5 clk = ~clk;

  palette_engine_if #(.NUM_BANKS(NB), .IDX_W(IW)) bus ();

  palette_engine #(.NUM_BANKS(NB), .IDX_W(IW), .FADE_DIV(FD)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [23:0] ramp [256];

  // Scoreboard compare point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic idle_inputs();
    bus.pixel_valid = 1'b0;
    bus.bank_sel    = '0;
    bus.pixel_idx   = '0;
    bus.wr_valid    = 1'b0;
    bus.wr_bank     = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.frame_tick  = 1'b0;
    bus.fade_start  = 1'b0;
    bus.fade_dir    = 1'b0;
  endtask

  task automatic write_entry(input logic [1:0] b, input logic [7:0] a, input logic [23:0] d);
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_bank  = b;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  // Single lookup; checks nothing valid after one edge and the color after two.
  task automatic lookup(input string tag, input logic [1:0] b, input logic [7:0] idx,
                        input logic [23:0] exp);
    @(negedge clk);
    bus.pixel_valid = 1'b1;
    bus.bank_sel    = b;
    bus.pixel_idx   = idx;
    @(negedge clk);
    bus.pixel_valid = 1'b0;
    check({tag, "_lat1"}, 32'(bus.color_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.color_valid), 32'd1);
    check({tag, "_color"}, 32'(bus.color_out), 32'(exp));
  endtask

  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic pulse_start(input logic dir);
    @(negedge clk);
    bus.fade_start = 1'b1;
    bus.fade_dir   = dir;
    @(negedge clk);
    bus.fade_start = 1'b0;
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i);
      ramp[i] = {v, ~v, v ^ 8'h5A};
    end

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_color_valid", 32'(bus.color_valid), 32'd0);
    check("rst_color_out",   32'(bus.color_out),   32'h0);
    check("rst_fade_busy",   32'(bus.fade_busy),   32'd0);
    check("rst_level",       32'(bus.dbg_level),   32'd16);
    check("rst_wr_ready",    32'(bus.wr_ready),    32'd1);
    bus.pixel_valid = 1'b1;
    #1;
    check("rst_wr_ready_pv", 32'(bus.wr_ready),    32'd0);
    bus.pixel_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic write then lookup with two-cycle latency
    write_entry(2'd1, 8'h05, 24'h6159A0);
    lookup("basic", 2'd1, 8'h05, 24'h6159A0);

    // Read has priority; the blocked write lands once pixel_valid drops
    @(negedge clk);
    bus.pixel_valid = 1'b1;
    bus.bank_sel    = 2'd1;
    bus.pixel_idx   = 8'h05;
    bus.wr_valid    = 1'b1;
    bus.wr_bank     = 2'd1;
    bus.wr_addr     = 8'h05;
    bus.wr_data     = 24'h123456;
    #1;
    check("collide_wr_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge clk);
    bus.pixel_valid = 1'b0;
    #1;
    check("collide_wr_ready_free", 32'(bus.wr_ready), 32'd1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    check("collide_old_data", 32'(bus.color_out), 32'h6159A0);
    lookup("collide_new", 2'd1, 8'h05, 24'h123456);

    // Bank isolation and out-of-range bank folding onto bank 0
    write_entry(2'd2, 8'h05, 24'h0000FF);
    lookup("bank1_kept", 2'd1, 8'h05, 24'h123456);
    lookup("bank2", 2'd2, 8'h05, 24'h0000FF);
    write_entry(2'd3, 8'h10, 24'hABCDEF);
    lookup("wr_oor", 2'd0, 8'h10, 24'hABCDEF);
    write_entry(2'd0, 8'h11, 24'h112233);
    lookup("rd_oor", 2'd3, 8'h11, 24'h112233);

    // Streaming: fill bank 2 back-to-back, then read 0..255 every cycle
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.wr_bank  = 2'd2;
      bus.wr_addr  = 8'(i);
      bus.wr_data  = ramp[i];
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
    for (int k = 0; k < 259; k++) begin
      @(negedge clk);
      check("stream_valid", 32'(bus.color_valid), 32'((k >= 2) && (k < 258)));
      if (k >= 2 && k < 258) check("stream_color", 32'(bus.color_out), 32'(ramp[k-2]));
      if (k < 256) begin
        bus.pixel_valid = 1'b1;
        bus.bank_sel    = 2'd2;
        bus.pixel_idx   = 8'(k);
      end else begin
        bus.pixel_valid = 1'b0;
      end
    end

    // Fade out; the tick coinciding with fade_start must not count
    write_entry(2'd0, 8'h20, 24'hF6E05D);
    @(negedge clk);
    bus.fade_start = 1'b1;
    bus.fade_dir   = 1'b0;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.fade_start = 1'b0;
    bus.frame_tick = 1'b0;
    check("fade_busy_on", 32'(bus.fade_busy), 32'd1);
    check("fade_state",   32'(bus.dbg_state), 32'(FADING));
    tick();
    check("fade_tick1", 32'(bus.dbg_level), 32'd16);
    tick();
    check("fade_tick2", 32'(bus.dbg_level), 32'd15);
    for (int i = 0; i < 14; i++) tick();
    check("fade_tick16", 32'(bus.dbg_level), 32'd8);
    lookup("fade_half", 2'd0, 8'h20, 24'h7B702E);
    pulse_start(1'b1);
    check("fade_restart_ignored", 32'(bus.fade_busy), 32'd1);
    tick();
    tick();
    check("fade_tick18", 32'(bus.dbg_level), 32'd7);
    for (int i = 0; i < 13; i++) tick();
    check("fade_tick31",      32'(bus.dbg_level), 32'd1);
    check("fade_tick31_busy", 32'(bus.fade_busy), 32'd1);
    tick();
    check("fade_tick32",      32'(bus.dbg_level), 32'd0);
    check("fade_tick32_busy", 32'(bus.fade_busy), 32'd0);
    lookup("fade_black", 2'd0, 8'h20, 24'h000000);
    tick();
    tick();
    check("fade_hold", 32'(bus.dbg_level), 32'd0);

    // Fade out while already black: one busy cycle, level unchanged
    pulse_start(1'b0);
    check("degen_busy", 32'(bus.fade_busy), 32'd1);
    @(negedge clk);
    check("degen_idle",  32'(bus.fade_busy), 32'd0);
    check("degen_level", 32'(bus.dbg_level), 32'd0);

    // Fade back in to full brightness
    pulse_start(1'b1);
    for (int i = 0; i < 32; i++) tick();
    check("fadein_level", 32'(bus.dbg_level), 32'd16);
    check("fadein_busy",  32'(bus.fade_busy), 32'd0);
    lookup("fadein_color", 2'd0, 8'h20, 24'hF6E05D);

    // Asynchronous reset mid-fade with two lookups in flight
    pulse_start(1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_level", 32'(bus.dbg_level), 32'd14);
    @(negedge clk);
    bus.pixel_valid = 1'b1;
    bus.bank_sel    = 2'd1;
    bus.pixel_idx   = 8'h05;
    @(negedge clk);
    bus.bank_sel    = 2'd0;
    bus.pixel_idx   = 8'h20;
    @(negedge clk);
    bus.pixel_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.color_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.color_valid), 32'd0);
    check("mid_rst_color", 32'(bus.color_out),   32'h0);
    check("mid_rst_busy",  32'(bus.fade_busy),   32'd0);
    check("mid_rst_level", 32'(bus.dbg_level),   32'd16);
    repeat (2) @(negedge clk);
    check("mid_rst_valid_hold", 32'(bus.color_valid), 32'd0);
    rst_n = 1'b1;
    lookup("post_rst_b1", 2'd1, 8'h05, 24'h123456);
    lookup("post_rst_b0", 2'd0, 8'h20, 24'hF6E05D);
    lookup("post_rst_b2", 2'd2, 8'h07, ramp[7]);

    // Report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/palette_engine.md
PALETTE_ENGINE -- requirements
Module: palette_engine

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of independent palette banks.
REQ-002 SHALL have parameter IDX_W, default 8, index width; each bank holds 2**IDX_W entries.
REQ-003 SHALL have parameter FADE_DIV, default 2, number of frame_tick pulses per fade step (minimum 1).
REQ-004 SHALL have port Clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port pixel_valid, input, 1, lookup request this cycle.
REQ-007 SHALL have port bank_sel, input, $clog2(NUM_BANKS), bank used for the lookup.
REQ-008 SHALL have port pixel_idx, input, IDX_W, palette index to look up.
REQ-009 SHALL have port color_out, output, 24, scaled RGB888 {R,G,B}.
REQ-010 SHALL have port color_valid, output, 1, color_out is valid.
REQ-011 SHALL have ports wr_valid (input, 1), wr_ready (output, 1), wr_bank (input, $clog2(NUM_BANKS)), wr_addr (input, IDX_W) and wr_data (input, 24), together forming the palette write port.
REQ-012 SHALL have port frame_tick, input, 1, one-cycle pulse per frame (vsync).
REQ-013 SHALL have ports fade_start (input, 1), fade_dir (input, 1; 0=out to black, 1=in from black) and fade_busy (output, 1).

Function
REQ-014 Lookup latency SHALL be exactly 2 cycles: a request accepted in cycle N gives color_out with color_valid=1 in cycle N+2; requests SHALL be accepted back-to-back every cycle.
REQ-015 Cycle 1 of a lookup SHALL perform the synchronous RAM read; cycle 2 SHALL apply brightness scaling using the level sampled in cycle 2.
REQ-016 Scaling SHALL compute each 8-bit channel as (ch*level)>>4, with level in 0..16 and a 13-bit intermediate; level 16 SHALL pass the color unchanged and level 0 SHALL give 0x000000.
REQ-017 A write transfer SHALL occur when wr_valid && wr_ready; wr_ready SHALL equal !pixel_valid, because reads have priority on the single-port RAM.
REQ-018 A completed write SHALL be visible to a lookup accepted in the following cycle or later.
REQ-019 Fade FSM states SHALL be IDLE and FADING.
REQ-020 In IDLE, fade_start SHALL move the FSM to FADING and latch fade_dir.
REQ-021 In FADING, level SHALL step by 1 (toward 0 for dir=0, toward 16 for dir=1) on every FADE_DIV-th frame_tick.
REQ-022 The FSM SHALL return to IDLE in the cycle level reaches its endpoint; level SHALL then hold.
REQ-023 fade_busy SHALL be 1 exactly while the FSM is in FADING.
REQ-024 fade_start SHALL be ignored while in FADING.
REQ-025 fade_start with dir=0 while level=0 (or dir=1 while level=16) SHALL enter FADING for one cycle and return to IDLE with level unchanged.
REQ-026 The frame_tick divider SHALL clear on entry to FADING.
REQ-027 frame_tick in the same cycle as fade_start SHALL NOT count toward the first step.
REQ-028 Out-of-range bank_sel or wr_bank (values >= NUM_BANKS) SHALL be treated as bank 0.

Reset
REQ-029 Asserting Reset_n low SHALL immediately clear color_out to 0x000000, color_valid to 0, fade_busy to 0, the FSM to IDLE, level to 16 and the divider to 0; this applies at any time, including mid-fade and with a lookup in flight.
REQ-030 Palette RAM contents SHALL NOT be reset: they are unspecified at power-up and retained across reset.
REQ-031 wr_ready SHALL follow REQ-017 during and after reset.

Structure
REQ-032 Package palette_pkg SHALL hold COLOR_W=24, LEVEL_MAX=16, the rgb_t packed struct {r,g,b} and the fade_state_t enum.
REQ-033 The block SHALL instantiate NUM_BANKS copies of the sub-module palette_ram (single-port, synchronous read, 2**IDX_W x 24).
REQ-034 Bank selection SHALL be registered alongside the read so that the output mux aligns with RAM data.

Verification
REQ-035 Write bank1 addr 0x05 = 0x6159A0, then lookup bank1 idx 0x05 -> color_out=0x6159A0 with color_valid exactly 2 cycles later.
REQ-036 pixel_valid=1 and wr_valid=1 in the same cycle -> wr_ready=0 and the write is not performed; deassert pixel_valid -> the write completes the next cycle.
REQ-037 Entry 0xF6E05D at level 16, fade_start dir=0 with FADE_DIV=2 -> level reaches 8 after 16 frame_ticks and color_out=0x7B702E; level reaches 0 after 32 ticks, fade_busy falls, output is 0x000000.
REQ-038 Streaming lookups on indices 0..255 on consecutive cycles -> 256 consecutive valid outputs in order, with no bubbles.
REQ-039 Assert Reset_n low mid-fade with 2 lookups in flight -> color_valid=0, fade_busy=0 and level=16 immediately; previously written RAM data reads back unchanged after reset.
